// File: rtl/program_mem_loadable.sv
// Run-time loadable program memory: core fetch port (pc -> ir) plus a streaming load port that
// Latency: fetch is registered, ir/ir_valid reflect pc sampled on the previous edge (RUN only).
// Backpressure: ld_ready is high only in LOAD; ld_valid low stalls the load indefinitely.
//
// Ports:
//   clk, res            clock and synchronous active-high reset
//   pc / ir, ir_valid   fetch address and registered instruction with its valid flag
//   ld_start            request a new load (honoured in RUN only)
//   ld_valid, ld_last,  load beat handshake, final-word marker and data word
//   ld_data, ld_ready
//   ld_done             one-cycle pulse when returning to RUN after a load
//   busy                high while loading or clearing
//   ld_count            words accepted by the most recent completed load
//
// Load words are written from address 0 upward. Any words past the final loaded word are
// then zeroed (NOP) by a CLEAR pass before fetch resumes.
module program_mem_loadable #(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ir_valid,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic                  ld_last,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  busy,
    output logic [PC_WIDTH:0]     ld_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = PC_WIDTH + 1;
    localparam logic [PC_WIDTH:0] DEPTH_W   = PW'(DEPTH);
    localparam logic [PC_WIDTH:0] LAST_ADDR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PC_WIDTH:0]     wptr;
    logic [PC_WIDTH:0]     wptr_inc;
    logic                  beat;
    logic                  load_end;
    logic                  clear_end;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  fetch_en;
    logic                  pc_in_range;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign wptr_inc    = wptr + 1'b1;
    assign beat        = (state == S_LOAD) && ld_valid;
    // Leaving LOAD either on the marked last word or on the top physical word.
    assign load_end    = beat && (ld_last || (wptr == LAST_ADDR));
    assign clear_end   = (state == S_CLEAR) && (wptr == LAST_ADDR);
    // Compare at PC_WIDTH+1 bits so DEPTH == 2^PC_WIDTH is handled.
    assign pc_in_range = ({1'b0, pc} < DEPTH_W);

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (ld_start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_end) begin
                    // A full-depth load leaves nothing to clear.
                    state_nxt = (wptr_inc < DEPTH_W) ? S_CLEAR : S_RUN;
                end
            end
            S_CLEAR: begin
                if (clear_end) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // Output / control decode
    always_comb begin
        ld_ready  = 1'b0;
        busy      = 1'b1;
        mem_we    = 1'b0;
        mem_wdata = ld_data;
        fetch_en  = 1'b0;
        case (state)
            S_RUN: begin
                busy     = 1'b0;
                // The fetch in the ld_start cycle is dropped.
                fetch_en = !ld_start;
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                mem_we   = ld_valid;
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (res) begin
            wptr     <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            ld_done  <= 1'b0;
            ld_count <= '0;
        end else begin
            ld_done <= (state != S_RUN) && (state_nxt == S_RUN);

            if ((state == S_RUN) && ld_start) begin
                wptr <= '0;
            end else if (mem_we) begin
                wptr <= wptr_inc;
            end

            if (load_end) begin
                ld_count <= wptr_inc;
            end

            if (fetch_en) begin
                ir       <= pc_in_range ? mem[pc[AW-1:0]] : '0;
                ir_valid <= 1'b1;
            end else begin
                ir       <= '0;
                ir_valid <= 1'b0;
            end
        end
    end

    // Memory array: contents are deliberately not reset; reset blocks any in-flight write.
    always_ff @(posedge clk) begin
        if (!res && mem_we) begin
            mem[wptr[AW-1:0]] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_program_mem_loadable.sv
module tb_program_mem_loadable;

    logic        clk = 1'b0;
    logic        res;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ld_start, ld_valid, ld_last;
    logic [15:0] ld_data;
    logic        ld_ready, ld_done, busy;
    logic [8:0]  ld_count;

    // Second instance with a shallow memory for out-of-range fetch behaviour.
    logic [7:0]  pc16;
    logic [15:0] ir16;
    logic        ir_valid16;
    logic        ld_start16, ld_valid16, ld_last16;
    logic [15:0] ld_data16;
    logic        ld_ready16, ld_done16, busy16;
    logic [8:0]  ld_count16;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    program_mem_loadable #(.PC_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256)) dut (
        .clk(clk), .res(res), .pc(pc), .ir(ir), .ir_valid(ir_valid),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_last(ld_last), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy), .ld_count(ld_count)
    );

    program_mem_loadable #(.PC_WIDTH(8), .DATA_WIDTH(16), .DEPTH(16)) dut16 (
        .clk(clk), .res(res), .pc(pc16), .ir(ir16), .ir_valid(ir_valid16),
        .ld_start(ld_start16), .ld_valid(ld_valid16), .ld_last(ld_last16), .ld_data(ld_data16),
        .ld_ready(ld_ready16), .ld_done(ld_done16), .busy(busy16), .ld_count(ld_count16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step until ld_done pulses, bounded; returns number of edges taken.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!ld_done && cnt < 1000) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        res = 1'b1; pc = '0;
        ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
        pc16 = '0; ld_start16 = 0; ld_valid16 = 0; ld_last16 = 0; ld_data16 = '0;

        // ---- Reset ----
        step(); step();
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ld_count", 32'(ld_count), 32'h0);
        chk("rst_ld_ready", 32'(ld_ready), 32'h0);
        chk("rst_ld_done", 32'(ld_done), 32'h0);
        res = 1'b0;
        step();
        chk("rel_ir_valid", 32'(ir_valid), 32'h1);

        // ---- Full-depth load: 256 beats, no ld_last ----
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("full_busy", 32'(busy), 32'h1);
        chk("full_ld_ready", 32'(ld_ready), 32'h1);
        chk("full_ir_valid", 32'(ir_valid), 32'h0);
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'(32'hA000 + i);
            step();
            if (i == 254) chk("full_busy_mid", 32'(busy), 32'h1);
        end
        ld_valid = 1'b0;
        chk("full_ld_done", 32'(ld_done), 32'h1);
        chk("full_busy_end", 32'(busy), 32'h0);
        chk("full_ld_count", 32'(ld_count), 32'd256);
        chk("full_exit_ir_valid", 32'(ir_valid), 32'h0);
        pc = 8'd255;
        step();
        chk("full_ir255", 32'(ir), 32'hA0FF);
        chk("full_ir_valid_run", 32'(ir_valid), 32'h1);
        chk("full_ld_done_pulse", 32'(ld_done), 32'h0);
        pc = 8'd0;
        step();
        chk("full_ir0", 32'(ir), 32'hA000);

        // ---- 3-word load followed by CLEAR ----
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 16'h4903; step();
        ld_data = 16'h4A14; step();
        ld_data = 16'h4BF0; ld_last = 1'b1; step();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("l3_clear_ld_ready", 32'(ld_ready), 32'h0);
        chk("l3_clear_busy", 32'(busy), 32'h1);
        chk("l3_ld_count", 32'(ld_count), 32'd3);
        wait_done(n);
        chk("l3_clear_cycles", 32'(n), 32'd253);
        chk("l3_busy_at_done", 32'(busy), 32'h0);
        chk("l3_exit_ir_valid", 32'(ir_valid), 32'h0);
        pc = 8'd0; step();
        chk("l3_ir0", 32'(ir), 32'h4903);
        chk("l3_ld_done_pulse", 32'(ld_done), 32'h0);
        pc = 8'd1; step(); chk("l3_ir1", 32'(ir), 32'h4A14);
        pc = 8'd2; step(); chk("l3_ir2", 32'(ir), 32'h4BF0);
        pc = 8'd3; step(); chk("l3_ir3_cleared", 32'(ir), 32'h0);
        pc = 8'd255; step(); chk("l3_ir255_cleared", 32'(ir), 32'h0);

        // ---- Back-pressure: ld_valid 1,0,0,1; ld_last on an idle cycle is ignored ----
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 16'h1111; step();
        ld_valid = 1'b0; ld_data = 16'h2222; ld_last = 1'b1; step();
        chk("bp_idle_last_ignored", 32'(ld_ready), 32'h1);
        ld_last = 1'b0; ld_data = 16'h3333; step();
        ld_valid = 1'b1; ld_data = 16'h4444; ld_last = 1'b1; step();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("bp_ld_count", 32'(ld_count), 32'd2);
        wait_done(n);
        chk("bp_clear_cycles", 32'(n), 32'd254);
        pc = 8'd0; step(); chk("bp_ir0", 32'(ir), 32'h1111);
        pc = 8'd1; step(); chk("bp_ir1", 32'(ir), 32'h4444);
        pc = 8'd2; step(); chk("bp_ir2", 32'(ir), 32'h0);

        // ---- Reset in the middle of a 5-word load ----
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 16'h5555; step();
        ld_data = 16'h6666; step();
        res = 1'b1; ld_data = 16'h7777; step();
        ld_valid = 1'b0;
        chk("ab_busy", 32'(busy), 32'h0);
        chk("ab_ld_done", 32'(ld_done), 32'h0);
        chk("ab_ld_count", 32'(ld_count), 32'h0);
        res = 1'b0;
        pc = 8'd0; step();
        chk("ab_ld_done_after", 32'(ld_done), 32'h0);
        chk("ab_ir0", 32'(ir), 32'h5555);
        pc = 8'd1; step(); chk("ab_ir1", 32'(ir), 32'h6666);
        pc = 8'd2; step(); chk("ab_ir2_unchanged", 32'(ir), 32'h0);

        // ---- DEPTH=16 instance: full load, then out-of-range fetches ----
        ld_start16 = 1'b1;
        step();
        ld_start16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ld_valid16 = 1'b1;
            ld_data16  = 16'(32'hB000 + i);
            step();
        end
        ld_valid16 = 1'b0;
        chk("d16_ld_done", 32'(ld_done16), 32'h1);
        chk("d16_ld_count", 32'(ld_count16), 32'd16);
        pc16 = 8'd15; step(); chk("d16_ir15", 32'(ir16), 32'hB00F);
        pc16 = 8'd16; step();
        chk("d16_ir16", 32'(ir16), 32'h0);
        chk("d16_ir16_valid", 32'(ir_valid16), 32'h1);
        pc16 = 8'd200; step();
        chk("d16_ir200", 32'(ir16), 32'h0);
        chk("d16_ir200_valid", 32'(ir_valid16), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
